// File: rtl/cvp14_pkg.sv
// Shared CVP14 definitions: operation and sequencer state encodings, vector
// geometry constants and bus widths.
package cvp14_pkg;

   localparam int LANES  = 16;
   localparam int WORD   = 16;
   localparam int VEC_W  = LANES * WORD;
   localparam int ADDR_W = 16;
   localparam int BEAT_W = $clog2(LANES);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

   typedef enum logic [1:0] {
      OP_VLD  = 2'b00,
      OP_VST  = 2'b01,
      OP_SST  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_STORE  = 3'd3,
      ST_SSTORE = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Extract lane idx (bits [16k+15:16k]) from a packed vector.
   function automatic logic [WORD-1:0] lane_word(input logic [VEC_W-1:0] vec,
                                                 input logic [BEAT_W-1:0] idx);
      return vec[int'(idx)*WORD +: WORD];
   endfunction

endpackage

// File: rtl/vec_lane_buf.sv
// LANES x WORD vector register written one lane per cycle by index.
// Holds its contents until a lane is rewritten or Reset is asserted.
module vec_lane_buf
   import cvp14_pkg::*;
(
   input  logic              Clk1,
   input  logic              Reset,
   input  logic              wr_en,
   input  logic [BEAT_W-1:0] wr_idx,
   input  logic [WORD-1:0]   wr_data,
   output logic [VEC_W-1:0]  data
);

   logic [WORD-1:0] lane_q [LANES];

   // Lane storage: cleared on reset, otherwise one indexed lane per write.
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < LANES; i++) begin
            lane_q[i] <= '0;
         end
      end else if (wr_en) begin
         lane_q[wr_idx] <= wr_data;
      end
   end

   // Pack lanes into the flat vector, lane k at bits [16k+15:16k].
   always_comb begin
      data = '0;
      for (int i = 0; i < LANES; i++) begin
         data[i*WORD +: WORD] = lane_q[i];
      end
   end

endmodule

// File: rtl/vector_mem_unit.sv
// Memory sequencer between CVP14 decode and the 16-bit memory bus.
// Splits VLD/VST into 16 single-word beats, issues SST as one beat, and
// assembles VLD read data into a 256-bit vector.
//
// Request handshake: an operation is accepted on a rising Clk1 edge where
// start_valid && start_ready. start_ready is high only in IDLE; the requester
// holds start_valid (and op/base_addr/wdata) until that edge. Requests while
// busy are ignored, not queued. op/base_addr/wdata are captured at acceptance.
module vector_mem_unit
   import cvp14_pkg::*;
(
   input  logic              Clk1,
   input  logic              Reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [VEC_W-1:0]  wdata,
   output logic [ADDR_W-1:0] Addr,
   output logic              RD,
   output logic              WR,
   output logic [WORD-1:0]   dataOut,
   input  logic [WORD-1:0]   DataIn,
   output logic [VEC_W-1:0]  rdata,
   output logic              done,
   output logic [2:0]        state_dbg
);

   state_e              state_q;
   state_e              state_d;
   logic [BEAT_W-1:0]   beat_q;
   logic [ADDR_W-1:0]   base_q;
   logic [VEC_W-1:0]    wdata_q;
   logic                accept;
   logic                last_beat;
   logic                cap_en;
   logic [BEAT_W-1:0]   cap_idx;
   logic [ADDR_W-1:0]   beat_addr;

   assign accept    = start_valid & start_ready;
   assign last_beat = (beat_q == LAST_BEAT);
   assign beat_addr = base_q + {{(ADDR_W-BEAT_W){1'b0}}, beat_q};
   assign state_dbg = state_q;

   // Sequencer state register.
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; the op chooses the path only at acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_e'(op))
                  OP_VLD:  state_d = ST_LOAD;
                  OP_VST:  state_d = ST_STORE;
                  OP_SST:  state_d = ST_SSTORE;
                  default: state_d = ST_DONE;
               endcase
            end
         end
         ST_LOAD:   if (last_beat) state_d = ST_DRAIN;
         ST_DRAIN:  state_d = ST_DONE;
         ST_STORE:  if (last_beat) state_d = ST_DONE;
         ST_SSTORE: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Beat counter: advances each LOAD/STORE beat, wraps to 0 after the last
   // beat (so it reads 0 in DRAIN), and is held at 0 everywhere else.
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         beat_q <= '0;
      end else if (state_q == ST_LOAD || state_q == ST_STORE) begin
         beat_q <= beat_q + BEAT_W'(1);
      end else begin
         beat_q <= '0;
      end
   end

   // Operand capture at acceptance so later input changes cannot disturb
   // the transfer in flight.
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         base_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         base_q  <= base_addr;
         wdata_q <= wdata;
      end
   end

   // Output decode from state and beat counter only; bus lines idle at zero.
   // Read data for beat k arrives one cycle later, when the counter already
   // reads k+1 (or 0 in DRAIN), hence the capture index of beat_q-1.
   always_comb begin
      start_ready = 1'b0;
      RD          = 1'b0;
      WR          = 1'b0;
      Addr        = '0;
      dataOut     = '0;
      done        = 1'b0;
      cap_en      = 1'b0;
      cap_idx     = beat_q - BEAT_W'(1);
      case (state_q)
         ST_IDLE: start_ready = 1'b1;
         ST_LOAD: begin
            RD     = 1'b1;
            Addr   = beat_addr;
            cap_en = (beat_q != '0);
         end
         ST_DRAIN: cap_en = 1'b1;
         ST_STORE: begin
            WR      = 1'b1;
            Addr    = beat_addr;
            dataOut = lane_word(wdata_q, beat_q);
         end
         ST_SSTORE: begin
            WR      = 1'b1;
            Addr    = base_q;
            dataOut = wdata_q[WORD-1:0];
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   vec_lane_buf u_rbuf (
      .Clk1    (Clk1),
      .Reset   (Reset),
      .wr_en   (cap_en),
      .wr_idx  (cap_idx),
      .wr_data (DataIn),
      .data    (rdata)
   );

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed-plus-random bench for vector_mem_unit with a bus memory responder
// and a word-level reference memory / expected-vector model.
module tb_vector_mem_unit;

   logic          Clk1 = 1'b0;
   logic          Reset = 1'b1;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [1:0]    op = 2'd0;
   logic [15:0]   base_addr = 16'd0;
   logic [255:0]  wdata = '0;
   logic [15:0]   Addr;
   logic          RD;
   logic          WR;
   logic [15:0]   dataOut;
   logic [15:0]   DataIn = 16'd0;
   logic [255:0]  rdata;
   logic          done;
   logic [2:0]    state_dbg;

   int            checks = 0;
   int            passes = 0;

   logic [15:0]   mem     [0:65535];
   logic [15:0]   ref_mem [0:65535];
   logic [255:0]  exp_rdata;

   vector_mem_unit dut (
      .Clk1        (Clk1),
      .Reset       (Reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .base_addr   (base_addr),
      .wdata       (wdata),
      .Addr        (Addr),
      .RD          (RD),
      .WR          (WR),
      .dataOut     (dataOut),
      .DataIn      (DataIn),
      .rdata       (rdata),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   always #5 Clk1 = ~Clk1;

   // Bus memory: writes on WR, read data returned the cycle after RD,
   // random garbage on DataIn otherwise.
   always @(posedge Clk1) begin
      if (WR === 1'b1) mem[Addr] <= dataOut;
      DataIn <= (RD === 1'b1) ? mem[Addr] : 16'($urandom);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk1);
      #1;
   endtask

   function automatic logic [255:0] rand_vec();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic scramble();
      op        = 2'($urandom);
      base_addr = 16'($urandom);
      wdata     = rand_vec();
   endtask

   function automatic int op_len(input int o);
      case (o)
         0:       return 18;
         1:       return 17;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic string op_name(input int o);
      case (o)
         0:       return "vld";
         1:       return "vst";
         2:       return "sst";
         default: return "rsvd";
      endcase
   endfunction

   // Expected bus behaviour for cycle c (1-based after acceptance).
   function automatic void exp_cycle(input int o, input logic [15:0] base,
                                     input logic [255:0] wd, input int c,
                                     output logic rd, output logic wr, output logic dn,
                                     output logic [15:0] addr, output logic [15:0] dout);
      rd = 1'b0; wr = 1'b0; dn = 1'b0; addr = 16'd0; dout = 16'd0;
      if (o == 0) begin
         if (c <= 16) begin rd = 1'b1; addr = base + 16'(c - 1); end
         if (c == 18) dn = 1'b1;
      end else if (o == 1) begin
         if (c <= 16) begin
            wr = 1'b1; addr = base + 16'(c - 1); dout = wd[(c-1)*16 +: 16];
         end
         if (c == 17) dn = 1'b1;
      end else if (o == 2) begin
         if (c == 1) begin wr = 1'b1; addr = base; dout = wd[15:0]; end
         if (c == 2) dn = 1'b1;
      end else begin
         if (c == 1) dn = 1'b1;
      end
   endfunction

   // Issue one operation from IDLE and check every cycle up to the IDLE after done.
   task automatic do_op(input int o, input logic [15:0] base, input logic [255:0] wd, input bit hold);
      logic rd_e, wr_e, dn_e;
      logic [15:0] addr_e, dout_e, a;
      int len;
      string nm;
      nm  = op_name(o);
      len = op_len(o);
      check({nm, " ready_at_issue"}, start_ready, 1);
      start_valid = 1'b1;
      op          = 2'(o);
      base_addr   = base;
      wdata       = wd;
      step();
      for (int c = 1; c <= len; c++) begin
         exp_cycle(o, base, wd, c, rd_e, wr_e, dn_e, addr_e, dout_e);
         check($sformatf("%s c%0d RD", nm, c), RD, rd_e);
         check($sformatf("%s c%0d WR", nm, c), WR, wr_e);
         check($sformatf("%s c%0d Addr", nm, c), Addr, addr_e);
         check($sformatf("%s c%0d dataOut", nm, c), dataOut, dout_e);
         check($sformatf("%s c%0d done", nm, c), done, dn_e);
         check($sformatf("%s c%0d ready", nm, c), start_ready, 0);
         check($sformatf("%s c%0d rd_wr_excl", nm, c), RD & WR, 0);
         start_valid = hold;
         scramble();
         step();
      end
      if (!hold) start_valid = 1'b0;
      // reference model update
      if (o == 0) begin
         for (int k = 0; k < 16; k++) begin
            a = base + 16'(k);
            exp_rdata[k*16 +: 16] = ref_mem[a];
         end
      end else if (o == 1) begin
         for (int k = 0; k < 16; k++) begin
            a = base + 16'(k);
            ref_mem[a] = wd[k*16 +: 16];
         end
      end else if (o == 2) begin
         ref_mem[base] = wd[15:0];
      end
      check({nm, " idle ready"}, start_ready, 1);
      check({nm, " idle done"}, done, 0);
      check({nm, " idle bus"}, {RD, WR, Addr, dataOut}, 0);
      check({nm, " rdata"}, rdata, exp_rdata);
      if (o == 1) begin
         for (int k = 0; k < 16; k++) begin
            a = base + 16'(k);
            check($sformatf("vst mem[%0h]", a), mem[a], ref_mem[a]);
         end
      end else if (o == 2) begin
         check($sformatf("sst mem[%0h]", base), mem[base], ref_mem[base]);
      end
   endtask

   // Start a VLD and assert Reset during beat 7.
   task automatic reset_mid(input logic [15:0] base);
      check("rst_mid ready_at_issue", start_ready, 1);
      start_valid = 1'b1;
      op          = 2'd0;
      base_addr   = base;
      wdata       = rand_vec();
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("rst_mid c%0d RD", c), RD, 1);
         step();
      end
      check("rst_mid beat7 RD", RD, 1);
      check("rst_mid beat7 Addr", Addr, base + 16'd7);
      #2 Reset = 1'b0;
      #1;
      check("rst_mid async bus", {RD, WR, Addr, dataOut}, 0);
      check("rst_mid async done", done, 0);
      check("rst_mid async ready", start_ready, 1);
      check("rst_mid async rdata", rdata, 0);
      exp_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_mid held done", done, 0);
         check("rst_mid held bus", {RD, WR, Addr}, 0);
      end
      #2 Reset = 1'b1;
      step();
      check("rst_mid post ready", start_ready, 1);
      check("rst_mid post rdata", rdata, 0);
      check("rst_mid post done", done, 0);
   endtask

   initial begin
      logic [255:0] wd;
      logic [15:0] b;
      int o;
      int gap;

      for (int a = 0; a < 65536; a++) begin
         mem[a]     = 16'(a) ^ 16'hA5A5;
         ref_mem[a] = 16'(a) ^ 16'hA5A5;
      end
      exp_rdata = '0;

      // reset state
      #1 Reset = 1'b0;
      #1;
      check("reset ready", start_ready, 1);
      check("reset bus", {RD, WR, Addr, dataOut}, 0);
      check("reset done", done, 0);
      check("reset rdata", rdata, 0);
      step();
      step();
      Reset = 1'b1;

      // VLD from 0x0100
      do_op(0, 16'h0100, rand_vec(), 1'b0);

      // VST to 0x0200 with lane k = 0x1000+k
      for (int k = 0; k < 16; k++) wd[k*16 +: 16] = 16'h1000 + 16'(k);
      do_op(1, 16'h0200, wd, 1'b0);

      // VLD across the address wrap
      do_op(0, 16'hFFF8, rand_vec(), 1'b0);

      // SST then reserved op
      wd = rand_vec();
      wd[15:0] = 16'hBEEF;
      do_op(2, 16'h0042, wd, 1'b0);
      do_op(3, 16'($urandom), rand_vec(), 1'b0);

      // read back the stored vector
      do_op(0, 16'h0200, rand_vec(), 1'b0);

      // reset in the middle of a load, then a fresh load
      reset_mid(16'($urandom));
      do_op(0, 16'($urandom), rand_vec(), 1'b0);

      // start_valid held high, alternating VLD/VST
      for (int i = 0; i < 6; i++) begin
         do_op(i % 2, 16'($urandom), rand_vec(), 1'b1);
      end
      start_valid = 1'b0;

      // random operations with random idle gaps
      for (int i = 0; i < 24; i++) begin
         o = $urandom_range(0, 3);
         b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
         do_op(o, b, rand_vec(), 1'b0);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            step();
            check("gap idle ready", start_ready, 1);
            check("gap idle done", done, 0);
            check("gap idle bus", {RD, WR, Addr}, 0);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
